eth_tx_frame_buf: RTL and testbench
===================================

Name: eth_tx_frame_buf

Overview:
Wishbone-programmable transmit frame buffer that sits directly upstream of eth_mac and drives its tx_axis_mac_* stream. Software uses a pointer and data window to fill a word RAM, writes the frame length, then issues a start command. The block streams the frame byte-by-byte, zero-pads runts to MIN_FRAME bytes, and reports completion through sticky status bits and an interrupt pulse.

Parameters:
DEPTH_WORDS, 16, buffer size in 32-bit words (DEPTH_BYTES = 4*DEPTH_WORDS); must be a power of two.
MIN_FRAME, 60, minimum number of bytes emitted per frame, before FCS; must be <= DEPTH_BYTES.

Ports:
clk_mac  in  1  MAC-domain clock; all logic is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
wb_adr_i  in  32  Wishbone address; only bits [5:2] are decoded.
wb_dat_i  in  32  Wishbone write data.
wb_sel_i  in  4  byte selects; ignored, every write is a full word.
wb_we_i  in  1  write enable.
wb_stb_i  in  1  strobe.
wb_cyc_i  in  1  cycle.
wb_dat_o  out  32  read data; valid while wb_ack_o is high.
wb_ack_o  out  1  single-cycle acknowledge.
wb_err_o  out  1  tied 0.
wb_rty_o  out  1  tied 0.
tx_axis_mac_tdata  out  8  frame byte.
tx_axis_mac_tvalid  out  1  byte valid.
tx_axis_mac_tlast  out  1  last byte of frame.
tx_axis_mac_tready  in  1  MAC accepts the byte.
tx_done_irq  out  1  one-cycle pulse when the last byte is accepted.

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, tvalid=0, tlast=0, tdata=0, tx_done_irq=0, LEN=0, PTR=0, done=0, err=0, state=IDLE. RAM contents are not reset.
- Wishbone access:
  - access = cyc&stb&~wb_ack_o; on that edge wb_ack_o<=1, otherwise 0. Every access completes with 1 cycle of latency.
  - Register writes and side effects take place on the access edge.
  - wb_dat_o is registered on the same edge.
- Register map (adr[5:2]):
  - 0 CTRL/STAT. Read: {29'b0, err, done, busy}. Write: bit0=1 requests start; bit1=1 clears done; bit2=1 clears err.
  - 1 LEN. R/W bits[10:0], frame length in bytes; upper bits read 0.
  - 2 PTR. R/W word pointer, log2(DEPTH_WORDS) bits.
  - 3 DATA. Write stores wb_dat_i at RAM[PTR], then PTR<=PTR+1, wrapping from DEPTH_WORDS-1 to 0. Read returns RAM[PTR] with no increment.
  - Any other offset: writes are ignored, reads return 0, and the access is still acked.
- Byte order: little-endian. Frame byte n = RAM[n>>2][8*(n%4)+7 : 8*(n%4)].
- Start validation:
  - Start is rejected (err<=1, stays IDLE) if LEN==0 or LEN>DEPTH_BYTES.
  - A start while busy is ignored; err is not set.
- While busy, writes to LEN, PTR and DATA are ignored but still acked. Reads work normally.
- State machine:
  - IDLE: on an accepted start, latch TOTAL=max(LEN,MIN_FRAME) and idx=0, then go to SEND. tvalid rises on the next cycle with byte 0.
  - SEND: tdata = (idx<LEN) ? frame byte idx : 8'h00. tlast = (idx==TOTAL-1).
    - On tvalid&tready: if tlast, go to DONE; otherwise idx<=idx+1 and the next byte is presented on the following cycle. Full throughput is 1 byte/cycle while tready stays high.
    - tvalid, tdata and tlast hold stable while tready=0; tvalid never deasserts mid-frame.
  - DONE: tvalid=0; tx_done_irq=1 for exactly this one cycle; done<=1; then return to IDLE.
- busy = (state != IDLE). A start written in the DONE cycle is ignored.
- Simultaneous events: a CTRL write carrying both a clear-done and a start clears done and starts. A done set in the same cycle as a clear-done write wins (done=1).
- Reset mid-frame: tvalid drops asynchronously. eth_mac is reset from the same rst_n, so the truncated frame is discarded by both sides.
- idx and TOTAL are 11 bits wide; no overflow is possible because TOTAL <= DEPTH_BYTES.

Test Plan:
1. Write PTR=0, DATA=0x6F746144, DATA=0x00000020, LEN=5, CTRL=1 -> stream 44 61 74 6F 20 followed by 55×00; 60 bytes total; tlast only on byte 59; tx_done_irq pulses once; STAT reads 0x2.
2. Fill 16 words with bytes 0x00..0x3F, LEN=64, start with tready held at 1 -> 64 consecutive bytes 00..3F on 64 consecutive cycles; tlast on 3F; PTR has wrapped to 0.
3. LEN=0, start -> no tvalid; STAT=0x4. Write CTRL=4 -> STAT=0. Repeat with LEN=65 -> same response.
4. 5-byte frame with tready toggling 1,0,0,1,… -> every byte is transferred once only; tdata/tlast are held during stalls; the byte sequence is identical to scenario 1.
5. During SEND: write DATA, LEN=10 and a second start -> all acked; RAM, LEN and PTR unchanged; only one frame is sent and err=0.
6. Assert rst_n low at byte 20 of a 60-byte frame -> tvalid=0 immediately; all registers at reset values. After reload and start, a complete correct frame is sent.

Source files
------------

// File: rtl/eth_tx_frame_buf.sv
// Transmit frame buffer loaded over Wishbone that feeds eth_mac's byte stream.
// It pads frames shorter than MIN_FRAME with zeros and reports completion with sticky status and an irq pulse.
//
// state | meaning
// IDLE  | waiting for start; LEN/PTR/DATA writable
// SEND  | streaming bytes 0..TOTAL-1 to the MAC
// DONE  | one-cycle completion: irq pulse, done set on exit

module eth_tx_frame_buf #(
    parameter int DEPTH_WORDS = 16,
    parameter int MIN_FRAME   = 60
) (
    input  logic        clk_mac,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [7:0]  tx_axis_mac_tdata,
    output logic        tx_axis_mac_tvalid,
    output logic        tx_axis_mac_tlast,
    input  logic        tx_axis_mac_tready,
    output logic        tx_done_irq
);

    localparam int          AW            = $clog2(DEPTH_WORDS);
    localparam logic [11:0] DEPTH_BYTES_W = 12'(4 * DEPTH_WORDS);
    localparam logic [10:0] MIN_FRAME_W   = 11'(MIN_FRAME);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_o_q, dat_o_d;
    logic [10:0]     len_q, len_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [10:0]     idx_q, idx_d;
    logic [10:0]     total_q, total_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [7:0]      tdata_q, tdata_d;
    logic            irq_q, irq_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            access, wr, ctrl_wr, busy, mem_we;
    logic [3:0]      reg_sel;
    logic [10:0]     nxt;
    logic [31:0]     nxt_word;
    logic            unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0]};

    assign reg_sel = wb_adr_i[5:2];
    assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = access & wb_we_i;
    assign ctrl_wr = wr && (reg_sel == 4'd0);
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        ack_d    = access;
        dat_o_d  = '0;
        len_d    = len_q;
        ptr_d    = ptr_q;
        done_d   = done_q;
        err_d    = err_q;
        idx_d    = idx_q;
        total_d  = total_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        irq_d    = 1'b0;
        mem_we   = 1'b0;
        nxt      = idx_q + 11'd1;
        nxt_word = mem_q[nxt[AW+1:2]];

        if (access && !wb_we_i) begin
            case (reg_sel)
                4'd0:    dat_o_d = {29'b0, err_q, done_q, busy};
                4'd1:    dat_o_d = 32'(len_q);
                4'd2:    dat_o_d = 32'(ptr_q);
                4'd3:    dat_o_d = mem_q[ptr_q];
                default: dat_o_d = '0;
            endcase
        end

        if (ctrl_wr && wb_dat_i[1]) done_d = 1'b0;
        if (ctrl_wr && wb_dat_i[2]) err_d  = 1'b0;

        if (wr && !busy) begin
            case (reg_sel)
                4'd1: len_d = wb_dat_i[10:0];
                4'd2: ptr_d = wb_dat_i[AW-1:0];
                4'd3: begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && wb_dat_i[0]) begin
                    if (len_q == '0 || {1'b0, len_q} > DEPTH_BYTES_W) begin
                        err_d = 1'b1;
                    end else begin
                        total_d  = (len_q < MIN_FRAME_W) ? MIN_FRAME_W : len_q;
                        idx_d    = '0;
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        tdata_d  = mem_q[0][7:0];
                        tlast_d  = (total_d == 11'd1);
                    end
                end
            end
            ST_SEND: begin
                if (tvalid_q && tx_axis_mac_tready) begin
                    if (tlast_q) begin
                        state_d  = ST_DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'h00;
                        irq_d    = 1'b1;
                    end else begin
                        idx_d   = nxt;
                        // bytes past LEN are the zero pad up to MIN_FRAME
                        tdata_d = (nxt < len_q) ? nxt_word[{nxt[1:0], 3'b000} +: 8] : 8'h00;
                        tlast_d = (nxt == total_q - 11'd1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            dat_o_q  <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            total_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_o_q  <= dat_o_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            total_q  <= total_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk_mac) begin
        if (mem_we) mem_q[ptr_q] <= wb_dat_i;
    end

    assign wb_dat_o           = dat_o_q;
    assign wb_ack_o           = ack_q;
    assign wb_err_o           = 1'b0;
    assign wb_rty_o           = 1'b0;
    assign tx_axis_mac_tdata  = tdata_q;
    assign tx_axis_mac_tvalid = tvalid_q;
    assign tx_axis_mac_tlast  = tlast_q;
    assign tx_done_irq        = irq_q;

endmodule

// File: tb/tb_eth_tx_frame_buf.sv
// Bench for eth_tx_frame_buf: a table of register vectors, then hand-written frame sequences
// whose expected bytes come from a bench-side copy of the buffer contents.

module tb_eth_tx_frame_buf;

    logic        clk_mac = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] wb_adr  = '0;
    logic [31:0] wb_dat  = '0;
    logic [3:0]  wb_sel  = 4'hF;
    logic        wb_we   = 1'b0;
    logic        wb_stb  = 1'b0;
    logic        wb_cyc  = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err, wb_rty;
    logic [7:0]  tdata;
    logic        tvalid, tlast, irq;
    logic        tready = 1'b1;

    eth_tx_frame_buf dut (
        .clk_mac            (clk_mac),
        .rst_n              (rst_n),
        .wb_adr_i           (wb_adr),
        .wb_dat_i           (wb_dat),
        .wb_sel_i           (wb_sel),
        .wb_we_i            (wb_we),
        .wb_stb_i           (wb_stb),
        .wb_cyc_i           (wb_cyc),
        .wb_dat_o           (wb_dat_o),
        .wb_ack_o           (wb_ack),
        .wb_err_o           (wb_err),
        .wb_rty_o           (wb_rty),
        .tx_axis_mac_tdata  (tdata),
        .tx_axis_mac_tvalid (tvalid),
        .tx_axis_mac_tlast  (tlast),
        .tx_axis_mac_tready (tready),
        .tx_done_irq        (irq)
    );

    initial forever #5 clk_mac = ~clk_mac;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // stream monitor: append-only records, the main thread works from snapshots
    logic [7:0] got[$];
    bit         got_last[$];
    int         got_cyc[$];
    int         cyc = 0, irq_cnt = 0, tv_cnt = 0, viol = 0, stall_cnt = 0;
    bit         prev_stall = 0;
    logic [7:0] sv_d;
    logic       sv_l, sv_v;

    always @(posedge clk_mac) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (tvalid && tready) begin
                got.push_back(tdata);
                got_last.push_back(tlast);
                got_cyc.push_back(cyc);
            end
            if (irq) irq_cnt <= irq_cnt + 1;
            if (tvalid) tv_cnt <= tv_cnt + 1;
            if (tvalid && !tready) stall_cnt <= stall_cnt + 1;
            if (prev_stall && (tvalid !== sv_v || tdata !== sv_d || tlast !== sv_l)) viol <= viol + 1;
            prev_stall <= tvalid && !tready;
            sv_d <= tdata;
            sv_l <= tlast;
            sv_v <= tvalid;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    logic [31:0] mdl_mem [16];
    logic [3:0]  mdl_ptr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called #1 after a rising edge; returns #1 after a rising edge
    task automatic wb(input bit we, input logic [3:0] adr, input logic [31:0] dat, output logic [31:0] rd);
        int n;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = {26'b0, adr, 2'b00}; wb_dat = dat;
        n = 0;
        do begin
            @(posedge clk_mac); #1; n++;
        end while (!wb_ack && n < 8);
        rd = wb_dat_o;
        check("ack_latency", n, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk_mac); #1;
        check("ack_single", wb_ack, 1'b0);
    endtask

    task automatic reg_wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        wb(1'b1, adr, dat, rd);
        if (adr == 4'd2) mdl_ptr = dat[3:0];
        else if (adr == 4'd3) begin
            mdl_mem[mdl_ptr] = dat;
            mdl_ptr++;
        end
    endtask

    task automatic reg_rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        wb(1'b0, adr, 32'h0, rd);
        check(name, rd, exp);
    endtask

    task automatic wait_frame(input int irq_base, input bit stall_pat);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tready = stall_pat ? (i % 3 == 0) : 1'b1;
            @(posedge clk_mac); #1;
            if (irq_cnt != irq_base) seen = 1;
        end
        tready = 1'b1;
        check("frame_end_seen", seen, 1);
        @(posedge clk_mac); #1;
    endtask

    task automatic check_frame(input int base, input int len, input int irq_base, input int viol_base);
        int total, n_chk, bad, lastbad;
        logic [31:0] w;
        logic [7:0]  e;
        total = (len < 60) ? 60 : len;
        n_chk = (got.size() - base < total) ? got.size() - base : total;
        bad = 0; lastbad = 0;
        for (int n = 0; n < n_chk; n++) begin
            w = mdl_mem[n / 4] >> (8 * (n % 4));
            e = (n < len) ? w[7:0] : 8'h00;
            if (got[base + n] !== e) bad++;
            if (got_last[base + n] != (n == total - 1)) lastbad++;
        end
        check("frame_bytes_count", got.size() - base, total);
        check("frame_byte_mismatches", bad, 0);
        check("frame_tlast_mismatches", lastbad, 0);
        check("irq_pulse_cycles", irq_cnt - irq_base, 1);
        check("stall_hold_violations", viol - viol_base, 0);
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input bit we, input logic [3:0] adr, input logic [31:0] dat, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        int          base, ib, vb, sb, tb0;
        logic [7:0]  e5[5];
        logic [31:0] rd;

        vecs.push_back(mk(0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2, 0, 32'h0));
        vecs.push_back(mk(1, 2, 5, 0));
        vecs.push_back(mk(0, 2, 0, 32'h5));
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 1, 0, 32'h7FF));
        vecs.push_back(mk(1, 2, 32'h13, 0));
        vecs.push_back(mk(0, 2, 0, 32'h3));
        vecs.push_back(mk(1, 3, 32'hA5A5_0001, 0));
        vecs.push_back(mk(0, 2, 0, 32'h4));
        vecs.push_back(mk(1, 2, 3, 0));
        vecs.push_back(mk(0, 3, 0, 32'hA5A5_0001));
        vecs.push_back(mk(0, 2, 0, 32'h3));
        vecs.push_back(mk(1, 2, 15, 0));
        vecs.push_back(mk(1, 3, 32'h1111_2222, 0));
        vecs.push_back(mk(0, 2, 0, 32'h0));
        vecs.push_back(mk(1, 7, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 7, 0, 32'h0));
        vecs.push_back(mk(0, 4, 0, 32'h0));
        vecs.push_back(mk(0, 15, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h7FF));
        vecs.push_back(mk(1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0));

        e5[0] = 8'h44; e5[1] = 8'h61; e5[2] = 8'h74; e5[3] = 8'h6F; e5[4] = 8'h20;

        repeat (3) @(posedge clk_mac);
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_ack", wb_ack, 1'b0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        check("err_rty_tied", {wb_err, wb_rty}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk_mac); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) reg_wr(vecs[i].adr, vecs[i].dat);
            else reg_rd(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d_read", i));
        end

        // runt frame padded to 60 bytes
        reg_wr(2, 0);
        reg_wr(3, 32'h6F74_6144);
        reg_wr(3, 32'h0000_0020);
        reg_wr(1, 5);
        base = got.size(); ib = irq_cnt; vb = viol;
        reg_wr(0, 1);
        wait_frame(ib, 0);
        check_frame(base, 5, ib, vb);
        for (int n = 0; n < 5; n++)
            if (got.size() > base + n) check($sformatf("s1_byte%0d", n), got[base + n], e5[n]);
        reg_rd(0, 32'h2, "s1_stat");

        // full 64-byte buffer at one byte per cycle; clear-done and start together
        reg_wr(2, 0);
        for (int k = 0; k < 16; k++)
            reg_wr(3, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        reg_wr(1, 64);
        base = got.size(); ib = irq_cnt; vb = viol;
        reg_wr(0, 3);
        reg_rd(0, 32'h1, "s2_stat_busy_done_cleared");
        wait_frame(ib, 0);
        check_frame(base, 64, ib, vb);
        if (got.size() >= base + 64)
            check("s2_back_to_back", got_cyc[base + 63] - got_cyc[base], 63);
        reg_rd(2, 32'h0, "s2_ptr_wrapped");

        // rejected starts: LEN 0 and LEN one past the buffer
        reg_wr(0, 2);
        reg_wr(1, 0);
        tb0 = tv_cnt;
        reg_wr(0, 1);
        repeat (5) @(posedge clk_mac);
        #1;
        check("s3_len0_no_tvalid", tv_cnt - tb0, 0);
        reg_rd(0, 32'h4, "s3_len0_stat");
        reg_wr(0, 4);
        reg_rd(0, 32'h0, "s3_err_cleared");
        reg_wr(1, 65);
        tb0 = tv_cnt;
        reg_wr(0, 1);
        repeat (5) @(posedge clk_mac);
        #1;
        check("s3_len65_no_tvalid", tv_cnt - tb0, 0);
        reg_rd(0, 32'h4, "s3_len65_stat");
        reg_wr(0, 4);

        // backpressure with tready 1,0,0 repeating
        reg_wr(2, 0);
        reg_wr(3, 32'h6F74_6144);
        reg_wr(3, 32'h0000_0020);
        reg_wr(1, 5);
        base = got.size(); ib = irq_cnt; vb = viol; sb = stall_cnt;
        reg_wr(0, 1);
        wait_frame(ib, 1);
        check_frame(base, 5, ib, vb);
        check("s4_stalls_seen", (stall_cnt - sb) > 40, 1'b1);

        // writes and a second start while busy are swallowed
        base = got.size(); ib = irq_cnt; vb = viol;
        reg_wr(0, 1);
        wb(1'b1, 3, 32'hDEAD_BEEF, rd);
        wb(1'b1, 1, 10, rd);
        wb(1'b1, 2, 7, rd);
        wb(1'b1, 0, 1, rd);
        reg_rd(1, 32'd5, "s5_len_unchanged");
        reg_rd(2, 32'd2, "s5_ptr_unchanged");
        wait_frame(ib, 0);
        check_frame(base, 5, ib, vb);
        repeat (80) @(posedge clk_mac);
        #1;
        check("s5_single_frame_irq", irq_cnt - ib, 1);
        check("s5_single_frame_bytes", got.size() - base, 60);
        reg_rd(0, 32'h2, "s5_stat_no_err");
        reg_rd(3, mdl_mem[2], "s5_ram_unchanged");

        // reset in the middle of a frame
        base = got.size(); ib = irq_cnt;
        reg_wr(0, 1);
        begin
            bit reached = 0;
            for (int i = 0; i < 200 && !reached; i++) begin
                if (got.size() - base >= 20) reached = 1;
                else begin @(posedge clk_mac); #1; end
            end
            check("s6_reached_byte20", reached, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("s6_tvalid_async_drop", tvalid, 1'b0);
        check("s6_tlast_reset", tlast, 1'b0);
        check("s6_irq_reset", irq, 1'b0);
        @(posedge clk_mac); @(posedge clk_mac); #1;
        rst_n = 1'b1;
        mdl_ptr = '0;
        @(posedge clk_mac); #1;
        reg_rd(0, 32'h0, "s6_stat_reset");
        reg_rd(1, 32'h0, "s6_len_reset");
        reg_rd(2, 32'h0, "s6_ptr_reset");
        check("s6_no_irq_truncated", irq_cnt - ib, 0);
        reg_wr(3, 32'h6F74_6144);
        reg_wr(3, 32'h0000_0020);
        reg_wr(1, 5);
        base = got.size(); ib = irq_cnt; vb = viol;
        reg_wr(0, 1);
        wait_frame(ib, 0);
        check_frame(base, 5, ib, vb);
        reg_rd(0, 32'h2, "s6_stat_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
